// File: rtl/execute_stage_md_if.sv
// rtl/execute_stage_md_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
interface execute_stage_md_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            RegWriteE, MemWriteE, ResultSrcE;
    logic            BranchE, JumpE, JalrE;
    logic [2:0]      BrFunctE;
    logic            ALUSrcE;
    logic [3:0]      ALUControlE;
    logic            MulDivE;
    logic [1:0]      MDOpE;
    logic            FlushE;
    logic [XLEN-1:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E;
    logic [REGW-1:0] RD_E;
    logic [XLEN-1:0] ResultW;
    logic [1:0]      ForwardA_E, ForwardB_E;

    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            StallE;
    logic            RegWriteM, MemWriteM, ResultSrcM;
    logic [REGW-1:0] RD_M;
    logic [XLEN-1:0] ALU_ResultM, WriteDataM, PCPlus4M;

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, JalrE, BrFunctE,
               ALUSrcE, ALUControlE, MulDivE, MDOpE, FlushE, RD1_E, RD2_E, ImmExtE,
               PCE, PCPlus4E, RD_E, ResultW, ForwardA_E, ForwardB_E,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALU_ResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, JalrE, BrFunctE,
               ALUSrcE, ALUControlE, MulDivE, MDOpE, FlushE, RD1_E, RD2_E, ImmExtE,
               PCE, PCPlus4E, RD_E, ResultW, ForwardA_E, ForwardB_E,
        output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALU_ResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - execute stage: forwarding, ALU, branch/jump, iterative mul/div, EX/MEM register
module execute_stage_md #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic              clk,
    input  logic              rst,
    execute_stage_md_if.slave ex
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

    md_state_e       state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [1:0]      op_q, op_d;

    logic            regwrite_q, memwrite_q, resultsrc_q;
    logic [REGW-1:0] rd_q;
    logic [XLEN-1:0] alu_result_q, write_data_q, pc_plus4_q;

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_out, jalr_sum, md_result;
    logic [SHW-1:0]  shamt;
    logic            br_eq, br_lt, br_ltu, br_cond, stall;

    // ALU_ResultM feeds back as a forwarding source
    always_comb begin
        case (ex.ForwardA_E)
            2'b01:   src_a = ex.ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = ex.RD1_E;
        endcase
        case (ex.ForwardB_E)
            2'b01:   fwd_b = ex.ResultW;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = ex.RD2_E;
        endcase
    end

    assign src_b = ex.ALUSrcE ? ex.ImmExtE : fwd_b;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        case (ex.ALUControlE)
            4'd0:    alu_out = src_a + src_b;
            4'd1:    alu_out = src_a - src_b;
            4'd2:    alu_out = src_a & src_b;
            4'd3:    alu_out = src_a | src_b;
            4'd4:    alu_out = src_a ^ src_b;
            4'd5:    alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'd6:    alu_out = {{(XLEN-1){1'b0}}, src_a < src_b};
            4'd7:    alu_out = src_a << shamt;
            4'd8:    alu_out = src_a >> shamt;
            4'd9:    alu_out = $signed(src_a) >>> shamt;
            default: alu_out = '0;
        endcase
    end

    // Branches compare against the forwarded register, never the immediate
    assign br_eq  = (src_a == fwd_b);
    assign br_lt  = ($signed(src_a) < $signed(fwd_b));
    assign br_ltu = (src_a < fwd_b);

    always_comb begin
        case (ex.BrFunctE)
            3'b000:  br_cond = br_eq;
            3'b001:  br_cond = ~br_eq;
            3'b100:  br_cond = br_lt;
            3'b101:  br_cond = ~br_lt;
            3'b110:  br_cond = br_ltu;
            3'b111:  br_cond = ~br_ltu;
            default: br_cond = 1'b0;
        endcase
    end

    assign jalr_sum     = src_a + ex.ImmExtE;
    assign ex.PCTargetE = ex.JalrE ? (jalr_sum & ~XLEN'(1)) : (ex.PCE + ex.ImmExtE);
    assign ex.PCSrcE    = (ex.JumpE | ex.JalrE | (ex.BranchE & br_cond)) & ~ex.FlushE;

    // Shared datapath: multiply keeps {partial_hi, multiplier} in {hi,lo};
    // divide keeps {remainder, dividend->quotient} in {hi,lo}.
    logic [XLEN:0] mul_sum, rem_shift, div_diff;
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    assign rem_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = rem_shift - {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (ex.MulDivE && !ex.FlushE) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = src_a;
                    b_d     = src_b;
                    op_d    = ex.MDOpE;
                end
            end
            BUSY: begin
                if (ex.FlushE) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!op_q[1]) begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end else begin
                        hi_d = div_diff[XLEN] ? rem_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
                    end
                    if (cnt_q == SHW'(XLEN-1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    // MULHU and REMU live in hi; MUL and DIVU in lo
    assign md_result = op_q[0] ? hi_q : lo_q;
    assign stall     = ex.MulDivE & (state_q != DONE) & ~ex.FlushE;
    assign ex.StallE = stall;

    always_ff @(posedge clk) begin
        if (rst || ex.FlushE || stall) begin
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            resultsrc_q  <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            regwrite_q   <= ex.RegWriteE;
            memwrite_q   <= ex.MemWriteE;
            resultsrc_q  <= ex.ResultSrcE;
            rd_q         <= ex.RD_E;
            alu_result_q <= ex.MulDivE ? md_result :
                            (ex.JumpE | ex.JalrE) ? ex.PCPlus4E : alu_out;
            write_data_q <= fwd_b;
            pc_plus4_q   <= ex.PCPlus4E;
        end
    end

    assign ex.RegWriteM   = regwrite_q;
    assign ex.MemWriteM   = memwrite_q;
    assign ex.ResultSrcM  = resultsrc_q;
    assign ex.RD_M        = rd_q;
    assign ex.ALU_ResultM = alu_result_q;
    assign ex.WriteDataM  = write_data_q;
    assign ex.PCPlus4M    = pc_plus4_q;
endmodule

// File: tb/tb_execute_stage_md.sv
// tb/tb_execute_stage_md.sv - directed bench for execute_stage_md
module tb_execute_stage_md;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    execute_stage_md_if #(.XLEN(32), .REGW(5)) ex ();
    execute_stage_md #(.XLEN(32), .REGW(5)) dut (.clk(clk), .rst(rst), .ex(ex.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex.RegWriteE = 0; ex.MemWriteE = 0; ex.ResultSrcE = 0;
        ex.BranchE = 0; ex.JumpE = 0; ex.JalrE = 0; ex.BrFunctE = 3'b010;
        ex.ALUSrcE = 0; ex.ALUControlE = 4'd0; ex.MulDivE = 0; ex.MDOpE = 2'b00;
        ex.FlushE = 0; ex.RD1_E = 0; ex.RD2_E = 0; ex.ImmExtE = 0; ex.PCE = 0;
        ex.PCPlus4E = 0; ex.RD_E = 0; ex.ResultW = 0; ex.ForwardA_E = 0; ex.ForwardB_E = 0;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_regwrite"}, 64'(ex.RegWriteM), 64'd0);
        chk({tag, "_alu"}, 64'(ex.ALU_ResultM), 64'd0);
        chk({tag, "_rd"}, 64'(ex.RD_M), 64'd0);
        chk({tag, "_pcp4"}, 64'(ex.PCPlus4M), 64'd0);
        chk({tag, "_wdata"}, 64'(ex.WriteDataM), 64'd0);
    endtask

    task automatic run_md(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int stalls = 0;
        int bubbles = 0;
        clear_inputs();
        ex.MulDivE = 1; ex.MDOpE = op; ex.RD1_E = a; ex.RD2_E = b;
        ex.RegWriteE = 1; ex.RD_E = 5'd7; ex.PCPlus4E = 32'h44;
        #1;
        while (ex.StallE === 1'b1 && stalls < 100) begin
            stalls++;
            tick();
            if (ex.RegWriteM === 1'b0 && ex.ALU_ResultM === 32'd0 && ex.RD_M === 5'd0)
                bubbles++;
            ex.RD1_E = ~a;
            ex.RD2_E = b + 32'd3;
        end
        chk({tag, "_stalls"}, 64'(stalls), 64'd33);
        chk({tag, "_bubbles"}, 64'(bubbles), 64'd33);
        tick();
        chk({tag, "_result"}, 64'(ex.ALU_ResultM), 64'(exp));
        chk({tag, "_regwrite"}, 64'(ex.RegWriteM), 64'd1);
        chk({tag, "_rd"}, 64'(ex.RD_M), 64'd7);
        ex.MulDivE = 0;
        ex.RegWriteE = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick();
        tick();
        chk_bubble("reset");
        chk("reset_stall", 64'(ex.StallE), 64'd0);
        chk("reset_pcsrc", 64'(ex.PCSrcE), 64'd0);
        rst = 0;

        // Seed ALU_ResultM = 7, then forward it into an ADDI
        ex.RD1_E = 32'd7; ex.ALUSrcE = 1; ex.ImmExtE = 0; ex.RegWriteE = 1; ex.RD_E = 5'd3;
        tick();
        chk("seed_alu", 64'(ex.ALU_ResultM), 64'd7);
        ex.RD1_E = 32'd5; ex.ForwardA_E = 2'b10; ex.ImmExtE = 32'd3;
        ex.MemWriteE = 1; ex.ForwardB_E = 2'b01; ex.ResultW = 32'h55;
        tick();
        chk("add_fwd_alu", 64'(ex.ALU_ResultM), 64'd10);
        chk("add_fwd_regwrite", 64'(ex.RegWriteM), 64'd1);
        chk("add_fwd_rd", 64'(ex.RD_M), 64'd3);
        chk("fwdb_wdata", 64'(ex.WriteDataM), 64'h55);
        chk("memwrite", 64'(ex.MemWriteM), 64'd1);

        clear_inputs();
        ex.RegWriteE = 1; ex.RD1_E = 32'd5; ex.RD2_E = 32'd7; ex.ALUControlE = 4'd1;
        tick();
        chk("sub", 64'(ex.ALU_ResultM), 64'hFFFF_FFFE);
        ex.RD1_E = 32'h8000_0000; ex.ALUSrcE = 1; ex.ImmExtE = 32'd4; ex.ALUControlE = 4'd9;
        tick();
        chk("sra", 64'(ex.ALU_ResultM), 64'hF800_0000);
        ex.ALUControlE = 4'd8;
        tick();
        chk("srl", 64'(ex.ALU_ResultM), 64'h0800_0000);
        ex.RD1_E = 32'd1; ex.RD2_E = 32'hFFFF_FFFF; ex.ALUSrcE = 0; ex.ALUControlE = 4'd6;
        tick();
        chk("sltu", 64'(ex.ALU_ResultM), 64'd1);
        ex.ALUControlE = 4'd5;
        tick();
        chk("slt", 64'(ex.ALU_ResultM), 64'd0);

        // BLT/BLTU with -1 vs 1; immediate on the B mux must not matter
        clear_inputs();
        ex.BranchE = 1; ex.BrFunctE = 3'b100; ex.RD1_E = 32'hFFFF_FFFF; ex.RD2_E = 32'd1;
        ex.ALUSrcE = 1; ex.PCE = 32'h100; ex.ImmExtE = 32'h20;
        #1;
        chk("blt_taken", 64'(ex.PCSrcE), 64'd1);
        chk("blt_target", 64'(ex.PCTargetE), 64'h120);
        ex.BrFunctE = 3'b110;
        #1;
        chk("bltu_not_taken", 64'(ex.PCSrcE), 64'd0);
        ex.BrFunctE = 3'b111;
        #1;
        chk("bgeu_taken", 64'(ex.PCSrcE), 64'd1);
        ex.BrFunctE = 3'b100; ex.FlushE = 1; ex.RegWriteE = 1; ex.RD_E = 5'd9;
        #1;
        chk("flush_gates_pcsrc", 64'(ex.PCSrcE), 64'd0);
        tick();
        chk("flush_bubble_regwrite", 64'(ex.RegWriteM), 64'd0);
        chk("flush_bubble_rd", 64'(ex.RD_M), 64'd0);

        clear_inputs();
        ex.JalrE = 1; ex.RD1_E = 32'h1001; ex.ImmExtE = 32'd4; ex.PCE = 32'h200;
        ex.PCPlus4E = 32'h204; ex.RegWriteE = 1; ex.RD_E = 5'd1;
        #1;
        chk("jalr_target", 64'(ex.PCTargetE), 64'h1004);
        chk("jalr_pcsrc", 64'(ex.PCSrcE), 64'd1);
        tick();
        chk("jalr_link", 64'(ex.ALU_ResultM), 64'h204);
        chk("jalr_pcp4", 64'(ex.PCPlus4M), 64'h204);

        run_md("mul", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run_md("mulhu", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        run_md("mul_mixed", 2'b00, 32'd1234, 32'd5678, 32'd7006652);
        run_md("divu", 2'b10, 32'd100, 32'd7, 32'd14);
        run_md("remu", 2'b11, 32'd100, 32'd7, 32'd2);
        run_md("divu_zero", 2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_md("remu_zero", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678);

        // Flush in the 10th BUSY cycle, then the next op must take the full latency
        clear_inputs();
        ex.MulDivE = 1; ex.RD1_E = 32'd3; ex.RD2_E = 32'd5; ex.RegWriteE = 1; ex.RD_E = 5'd4;
        tick();
        repeat (9) tick();
        ex.FlushE = 1;
        #1;
        chk("flush_busy_stall", 64'(ex.StallE), 64'd0);
        tick();
        chk("flush_busy_regwrite", 64'(ex.RegWriteM), 64'd0);
        ex.FlushE = 0; ex.MulDivE = 0; ex.RegWriteE = 0;
        run_md("after_flush", 2'b10, 32'd100, 32'd7, 32'd14);

        // Reset mid-BUSY
        clear_inputs();
        ex.MulDivE = 1; ex.MDOpE = 2'b01; ex.RD1_E = 32'hFFFF_FFFF; ex.RD2_E = 32'hFFFF_FFFF;
        ex.RegWriteE = 1; ex.RD_E = 5'd6; ex.PCPlus4E = 32'h88;
        tick();
        repeat (5) tick();
        rst = 1;
        tick();
        chk_bubble("rst_busy");
        rst = 0;
        ex.MulDivE = 0;
        tick();
        run_md("after_rst", 2'b11, 32'd100, 32'd7, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
